pri_enc_arb: RTL and testbench
==============================

// Module: pri_enc_arb
// PURPOSE
//  Parametrised, registered successor to the 8:3 priority encoder. Turns N request
//  lines into a binary index, a one-hot grant and a valid flag. Two modes:
//  fixed (highest index wins) and round-robin. The grant is held until the consumer
//  acks it. A saturating grant counter supports debug. Sits between request sources
//  and a shared resource.
// PARAMETERS
//  N       8   number of request inputs (N >= 2; non-power-of-two allowed)
//  CNT_W   16  width of saturating grant counter
//  W       -   localparam = $clog2(N), index width
// PORTS
//  clk    in   1      clock, all state on rising edge
//  rst    in   1      synchronous reset, active-high
//  in     in   N      request vector, bit i = requester i
//  mode   in   1      0 = fixed priority, 1 = round-robin
//  ack    in   1      consumer accepts current grant (sampled only while valid=1)
//  out    out  W      index of granted requester
//  grant  out  N      one-hot of out; all zero when valid=0
//  valid  out  1      grant present and stable
//  gcnt   out  CNT_W  number of grants issued, saturating at all-ones
// BEHAVIOUR
//  - Reset (rst=1 at edge): out=0, grant=0, valid=0, gcnt=0, ptr=N-1, state=IDLE.
//    Reset overrides any in-flight grant.
//  - All outputs are registered. A request is seen at edge k and the grant
//    appears after edge k (latency 1).
//  - Arbitration function arb(in, ptr, mode):
//    - fixed: highest set index wins; ptr is ignored.
//    - RR: search order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1; the first set
//      bit wins. With ptr=N-1, RR is identical to fixed.
//  - FSM, two states:
//    - IDLE: if |in, load out/grant with arb(in,ptr,mode), set valid=1, go BUSY.
//      Otherwise stay IDLE; ack is ignored.
//    - BUSY: out, grant and valid are frozen; changes on in or mode have no effect.
//      When ack=1:
//      - RR mode: ptr <= (out==0) ? N-1 : out-1. Fixed mode: ptr is unchanged.
//      - Back-to-back: if |in, load arb(in, ptr_next, mode) in the same edge. valid
//        stays 1 and the state stays BUSY. Otherwise valid<=0, grant<=0, and the
//        state goes IDLE. out keeps its last value.
//      - In fixed mode, a requester that still asserts after ack is granted again.
//  - gcnt increments by 1 on every edge that loads a new grant (IDLE->BUSY or
//    back-to-back). It holds at 2^CNT_W-1. Only rst clears it.
//  - Index arithmetic is modulo N: the ptr wrap uses an explicit compare with 0,
//    not W-bit overflow. Values of out >= N never occur.
//  - Requester deasserting while granted: the grant is held until ack. No cancel.
// TESTING
//  1. rst=1 for 2 clk -> out=0, grant=0, valid=0, gcnt=0. ack=1 in IDLE ->
//     no change.
//  2. mode=0, in=8'h2C -> next cycle out=5, grant=8'h20, valid=1. Set in=8'h80
//     without ack for 3 cycles -> out stays 5.
//  3. mode=0, in=8'h2C held, ack=1 one cycle -> out=5 again, valid stays 1,
//     gcnt=2. in=0 then ack -> valid=0, grant=0.
//  4. mode=1, in=8'hFF, ack=1 every cycle -> out sequence 7,6,5,4,3,2,1,0,7 and
//     gcnt increments by 1 each cycle.
//  5. N=5, mode=1, in=5'b00001, ack -> ptr wraps to 4. Then in=5'b10001 -> out=4.
//     rst asserted while valid=1 -> all outputs zero the next cycle.
//  6. CNT_W=4, mode=1, in=8'hFF, 20 acked grants -> gcnt=15 and holds.

Source files
------------

// File: rtl/pri_enc_arb.sv
// Registered N-way priority encoder / arbiter with fixed and round-robin modes.
// A grant is held until ack; back-to-back grants are loaded on the ack edge.
//
//   state | meaning
//   IDLE  | no grant outstanding, waiting for any request
//   BUSY  | grant frozen on out/grant, waiting for ack
module pri_enc_arb #(
  parameter int N = 8,
  parameter int CNT_W = 16,
  localparam int W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in,
  input  logic             mode,
  input  logic             ack,
  output logic [W-1:0]     out,
  output logic [N-1:0]     grant,
  output logic             valid,
  output logic [CNT_W-1:0] gcnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     out_q, out_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic             load;

  // Requests at or below p are searched first (downwards); if none, the
  // highest request overall wins, which is the wrap-around part of the order.
  function automatic logic [W-1:0] arb(input logic [N-1:0] req,
                                       input logic [W-1:0] p,
                                       input logic rr);
    logic [N-1:0] lo;
    logic [W-1:0] idx;
    lo = '0;
    for (int i = 0; i < N; i++) lo[i] = !rr || (W'(i) <= p);
    lo = req & lo;
    if (lo == '0) lo = req;
    idx = '0;
    for (int i = 0; i < N; i++) if (lo[i]) idx = W'(i);
    return idx;
  endfunction

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    gcnt_d  = gcnt_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (|in) load = 1'b1;
      BUSY: begin
        if (ack) begin
          if (mode) ptr_d = (out_q == '0) ? W'(N - 1) : out_q - 1'b1;
          if (|in) begin
            load = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      out_d   = arb(in, ptr_d, mode);
      grant_d = N'(1) << out_d;
      state_d = BUSY;
      gcnt_d  = (gcnt_q == '1) ? gcnt_q : gcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q   <= '0;
      grant_q <= '0;
      ptr_q   <= W'(N - 1);
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      gcnt_q  <= gcnt_d;
    end
  end

  assign out   = out_q;
  assign grant = grant_q;
  assign valid = (state_q == BUSY);
  assign gcnt  = gcnt_q;

endmodule

// File: tb/tb_pri_enc_arb.sv
// Bench for pri_enc_arb: three instances (N=8, N=5, small counter) checked every
// cycle against a behavioural model, plus hand-computed directed checks.
module tb_pri_enc_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  // dut_a: N=8 CNT_W=16, dut_b: N=5 CNT_W=16, dut_c: N=8 CNT_W=4
  logic rst_a = 1, mode_a = 0, ack_a = 0;
  logic rst_b = 1, mode_b = 0, ack_b = 0;
  logic rst_c = 1, mode_c = 0, ack_c = 0;
  logic [7:0] in_a = '0, in_c = '0;
  logic [4:0] in_b = '0;
  logic [2:0] out_a, out_b, out_c;
  logic [7:0] grant_a, grant_c;
  logic [4:0] grant_b;
  logic valid_a, valid_b, valid_c;
  logic [15:0] gcnt_a, gcnt_b;
  logic [3:0] gcnt_c;

  pri_enc_arb #(.N(8), .CNT_W(16)) dut_a (.clk(clk), .rst(rst_a), .in(in_a), .mode(mode_a),
    .ack(ack_a), .out(out_a), .grant(grant_a), .valid(valid_a), .gcnt(gcnt_a));
  pri_enc_arb #(.N(5), .CNT_W(16)) dut_b (.clk(clk), .rst(rst_b), .in(in_b), .mode(mode_b),
    .ack(ack_b), .out(out_b), .grant(grant_b), .valid(valid_b), .gcnt(gcnt_b));
  pri_enc_arb #(.N(8), .CNT_W(4)) dut_c (.clk(clk), .rst(rst_c), .in(in_c), .mode(mode_c),
    .ack(ack_c), .out(out_c), .grant(grant_c), .valid(valid_c), .gcnt(gcnt_c));

  typedef struct packed {
    int out;
    bit valid;
    int gcnt;
    int ptr;
  } mst_t;

  mst_t ma, mb, mc;

  // Walk the search order explicitly: start index, then downward modulo n.
  function automatic int arb_m(int req, int n, int ptr, bit rr);
    int p = rr ? ptr : n - 1;
    for (int k = 0; k < n; k++) begin
      int idx = (p - k + n) % n;
      if (((req >> idx) & 1) != 0) return idx;
    end
    return 0;
  endfunction

  function automatic mst_t step_m(mst_t s, int n, int cmax, int req, bit md, bit ak, bit rs);
    mst_t r = s;
    bit ld = 0;
    if (rs) begin
      r.out = 0; r.valid = 0; r.gcnt = 0; r.ptr = n - 1;
      return r;
    end
    if (!s.valid) begin
      ld = (req != 0);
    end else if (ak) begin
      if (md) r.ptr = (s.out == 0) ? n - 1 : s.out - 1;
      if (req != 0) ld = 1;
      else r.valid = 0;
    end
    if (ld) begin
      r.out = arb_m(req, n, r.ptr, md);
      r.valid = 1;
      if (r.gcnt < cmax) r.gcnt = r.gcnt + 1;
    end
    return r;
  endfunction

  function automatic int grant_m(mst_t s);
    return s.valid ? (1 << s.out) : 0;
  endfunction

  always @(posedge clk) begin
    ma <= step_m(ma, 8, 65535, int'(in_a), mode_a, ack_a, rst_a);
    mb <= step_m(mb, 5, 65535, int'(in_b), mode_b, ack_b, rst_b);
    mc <= step_m(mc, 8, 15, int'(in_c), mode_c, ack_c, rst_c);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_out", 32'(out_a), 32'(ma.out));
      chk("a_grant", 32'(grant_a), 32'(grant_m(ma)));
      chk("a_valid", 32'(valid_a), 32'(ma.valid));
      chk("a_gcnt", 32'(gcnt_a), 32'(ma.gcnt));
      chk("b_out", 32'(out_b), 32'(mb.out));
      chk("b_grant", 32'(grant_b), 32'(grant_m(mb)));
      chk("b_valid", 32'(valid_b), 32'(mb.valid));
      chk("b_gcnt", 32'(gcnt_b), 32'(mb.gcnt));
      chk("c_out", 32'(out_c), 32'(mc.out));
      chk("c_grant", 32'(grant_c), 32'(grant_m(mc)));
      chk("c_valid", 32'(valid_c), 32'(mc.valid));
      chk("c_gcnt", 32'(gcnt_c), 32'(mc.gcnt));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, ack in IDLE does nothing
    cyc(2);
    chk_en = 1;
    rst_a = 0;
    chk("t1_out", 32'(out_a), 0);
    chk("t1_grant", 32'(grant_a), 0);
    chk("t1_valid", 32'(valid_a), 0);
    chk("t1_gcnt", 32'(gcnt_a), 0);
    ack_a = 1; cyc(1); ack_a = 0;
    chk("t1_ack_idle_valid", 32'(valid_a), 0);
    chk("t1_ack_idle_gcnt", 32'(gcnt_a), 0);

    // fixed priority, grant frozen while BUSY
    in_a = 8'h2C; cyc(1);
    chk("t2_out", 32'(out_a), 5);
    chk("t2_grant", 32'(grant_a), 32'h20);
    chk("t2_valid", 32'(valid_a), 1);
    in_a = 8'h80; cyc(3);
    chk("t2_hold_out", 32'(out_a), 5);
    chk("t2_hold_grant", 32'(grant_a), 32'h20);

    // back-to-back in fixed mode regrants the same requester
    in_a = 8'h2C; ack_a = 1; cyc(1); ack_a = 0;
    chk("t3_out", 32'(out_a), 5);
    chk("t3_valid", 32'(valid_a), 1);
    chk("t3_gcnt", 32'(gcnt_a), 2);
    in_a = 8'h00; cyc(1);
    ack_a = 1; cyc(1); ack_a = 0;
    chk("t3_release_valid", 32'(valid_a), 0);
    chk("t3_release_grant", 32'(grant_a), 0);
    chk("t3_release_out", 32'(out_a), 5);

    // round-robin rotation, ptr still N-1 since fixed mode left it alone
    mode_a = 1; in_a = 8'hFF; ack_a = 1;
    for (int k = 0; k < 9; k++) begin
      cyc(1);
      chk("t4_rr_out", 32'(out_a), 32'((7 - k + 8) % 8));
      chk("t4_rr_gcnt", 32'(gcnt_a), 32'(3 + k));
    end
    in_a = 8'h00; cyc(1); ack_a = 0;
    chk("t4_idle_valid", 32'(valid_a), 0);

    // N=5 pointer wrap and reset while valid
    rst_b = 0; mode_b = 1; in_b = 5'b00001; cyc(1);
    chk("t5_first_out", 32'(out_b), 0);
    in_b = 5'b00000; ack_b = 1; cyc(1); ack_b = 0;
    chk("t5_released", 32'(valid_b), 0);
    in_b = 5'b10001; cyc(1);
    chk("t5_wrap_out", 32'(out_b), 4);
    chk("t5_wrap_grant", 32'(grant_b), 32'h10);
    rst_b = 1; cyc(1);
    chk("t5_rst_out", 32'(out_b), 0);
    chk("t5_rst_grant", 32'(grant_b), 0);
    chk("t5_rst_valid", 32'(valid_b), 0);
    chk("t5_rst_gcnt", 32'(gcnt_b), 0);
    rst_b = 0; in_b = 5'b00000;

    // saturation on 4-bit counter
    rst_c = 0; mode_c = 1; in_c = 8'hFF; ack_c = 1;
    cyc(20);
    chk("t6_gcnt_sat", 32'(gcnt_c), 15);
    cyc(3);
    chk("t6_gcnt_hold", 32'(gcnt_c), 15);
    ack_c = 0; in_c = 8'h00;

    // mixed traffic: mode and requests change, including while BUSY
    for (int k = 0; k < 60; k++) begin
      in_a = 8'($urandom);
      in_b = 5'($urandom);
      in_c = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      mode_a = 1'($urandom); mode_b = 1'($urandom); mode_c = 1'($urandom);
      ack_a = 1'($urandom); ack_b = 1'($urandom); ack_c = 1'($urandom);
      cyc(1);
    end

    // reset dut_a while a grant is outstanding
    in_a = 8'h01; ack_a = 0; cyc(1);
    rst_a = 1; cyc(1); rst_a = 0;
    chk("t7_rst_valid", 32'(valid_a), 0);
    chk("t7_rst_gcnt", 32'(gcnt_a), 0);
    in_a = 8'h00;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
